button_uart_tx: RTL and testbench

- Downstream consumer of the debounced push-button level.
- Detects the rising edge of the debounced "send" level and captures the 8-bit switch value on `data_in`.
- Transmits the captured byte as one UART 8N1 frame on `tx`.
- One button press produces exactly one frame. Edges that arrive while a frame is in flight are dropped.

---
 rtl/button_uart_tx_if.sv | 25 ++
 rtl/button_uart_tx.sv | 133 +++++++++++++
 tb/tb_button_uart_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_uart_tx_if.sv
// Button-to-UART bus: debounced send level and switch byte in, serial line and status out.
// The slave modport is the transmitter side; master is whatever drives the button/switches.
interface button_uart_tx_if;
  logic       send_in;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       done;

  modport slave (
    input  send_in,
    input  data_in,
    output tx,
    output busy,
    output done
  );

  modport master (
    output send_in,
    output data_in,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/button_uart_tx.sv
// Sends the switch byte as one UART 8N1 frame on each rising edge of the debounced button level.
// Edges seen while a frame is in flight are dropped rather than queued.
module button_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  localparam int unsigned CNT_W       = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  button_uart_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic             send_prev_q, send_prev_d;
  logic             tx_q,        tx_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  logic rise;
  logic bit_end;

  assign rise    = bus.send_in & ~send_prev_q;
  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    // Tracks the level in every state so a press held past the frame end is not a new edge.
    send_prev_d = bus.send_in;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        if (rise) begin
          shift_d = bus.data_in;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q != 3'd7) begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end else begin
            tx_d    = 1'b1;
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      send_prev_q <= 1'b1;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      send_prev_q <= send_prev_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_button_uart_tx.sv
// Bench for button_uart_tx: table of button presses plus directed corner cases, with a
// frame monitor that decodes tx and checks each frame against a queue of expected bytes.
module tb_button_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned CPB_B = 10416;

  logic clk;
  logic rst_n;
  logic rst_b_n;

  button_uart_tx_if bus_a ();
  button_uart_tx_if bus_b ();

  button_uart_tx #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  button_uart_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [7:0]  exp_q[$];
  int unsigned frames_done = 0;
  int unsigned stray_done  = 0;

  typedef struct {
    logic [7:0]  data;
    int unsigned hold;
    int unsigned chg_at;
    logic [7:0]  chg_val;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Decodes one frame starting at the first negedge where busy is seen high.
  task automatic run_frame();
    logic [9:0] bits;
    bit         unstable;
    bit         bad_busy;
    bit         early_done;
    bit         aborted;
    logic [7:0] exp_byte;
    bits       = '0;
    unstable   = 1'b0;
    bad_busy   = 1'b0;
    early_done = 1'b0;
    aborted    = 1'b0;
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (!rst_n) begin
        aborted = 1'b1;
        break;
      end
      if (bus_a.busy !== 1'b1) bad_busy = 1'b1;
      if (bus_a.done !== 1'b0) early_done = 1'b1;
      if (k % CPB == 0) bits[k / CPB] = bus_a.tx;
      else if (bus_a.tx !== bits[k / CPB]) unstable = 1'b1;
    end
    if (!aborted) begin
      @(negedge clk);
      if (rst_n) begin
        frames_done++;
        check("frame_start_bit", {31'd0, bits[0]}, 32'd0);
        check("frame_stop_bit", {31'd0, bits[9]}, 32'd1);
        check("frame_bit_stable", {31'd0, unstable}, 32'd0);
        check("frame_busy_held", {31'd0, bad_busy}, 32'd0);
        check("frame_no_early_done", {31'd0, early_done}, 32'd0);
        check("frame_end_done_busy", {30'd0, bus_a.done, bus_a.busy}, 32'd2);
        if (exp_q.size() == 0) begin
          check("frame_unexpected", 32'd1, 32'd0);
        end else begin
          exp_byte = exp_q.pop_front();
          check("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_byte});
        end
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus_a.busy === 1'b1) run_frame();
      else if (bus_a.done === 1'b1) stray_done++;
    end
  end

  task automatic wait_frames(input int unsigned target);
    for (int i = 0; i < 1000 && frames_done < target; i++) @(negedge clk);
    check("frame_timeout", {31'd0, frames_done >= target}, 32'd1);
  endtask

  task automatic press(input logic [7:0] data);
    @(negedge clk);
    bus_a.data_in = data;
    bus_a.send_in = 1'b1;
    @(negedge clk);
    bus_a.send_in = 1'b0;
  endtask

  initial begin : stimulus
    int unsigned base;
    int unsigned n;
    bit          idle_bad;
    logic        lvl;

    vecs[0] = '{8'h55, 1,   0,  8'h00, 8'h55};
    vecs[1] = '{8'hA3, 200, 10, 8'hFF, 8'hA3};
    vecs[2] = '{8'h00, 3,   0,  8'h00, 8'h00};
    vecs[3] = '{8'hFF, 1,   0,  8'h00, 8'hFF};
    vecs[4] = '{8'h81, 50,  5,  8'h00, 8'h81};

    rst_n         = 1'b1;
    rst_b_n       = 1'b1;
    bus_a.send_in = 1'b0;
    bus_a.data_in = 8'h00;
    bus_b.send_in = 1'b0;
    bus_b.data_in = 8'h00;
    #2 rst_n = 1'b0;
    rst_b_n = 1'b0;
    #1;
    check("reset_tx", {31'd0, bus_a.tx}, 32'd1);
    check("reset_busy", {31'd0, bus_a.busy}, 32'd0);
    check("reset_done", {31'd0, bus_a.done}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    idle_bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus_a.tx !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) idle_bad = 1'b1;
    end
    check("idle_100_cycles", {31'd0, idle_bad}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      base = frames_done;
      @(negedge clk);
      bus_a.data_in = vecs[v].data;
      bus_a.send_in = 1'b1;
      exp_q.push_back(vecs[v].exp_byte);
      for (int unsigned c = 1; c <= vecs[v].hold; c++) begin
        @(negedge clk);
        if (c == 1) check("latency_tx_busy", {30'd0, bus_a.tx, bus_a.busy}, 32'd1);
        if (c == vecs[v].chg_at) bus_a.data_in = vecs[v].chg_val;
      end
      bus_a.send_in = 1'b0;
      wait_frames(base + 1);
      repeat (60) @(negedge clk);
      check("vec_one_frame", frames_done, base + 1);
    end

    // Button held through reset release must not start a frame.
    base = frames_done;
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus_a.send_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("held_reset_no_frame", frames_done, base);
    check("held_reset_idle", {31'd0, bus_a.busy}, 32'd0);
    bus_a.send_in = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h5A);
    press(8'h5A);
    wait_frames(base + 1);

    // Second rise 12 cycles into the frame is ignored.
    base = frames_done;
    exp_q.push_back(8'hC3);
    press(8'hC3);
    repeat (11) @(negedge clk);
    bus_a.data_in = 8'h11;
    bus_a.send_in = 1'b1;
    @(negedge clk);
    bus_a.send_in = 1'b0;
    wait_frames(base + 1);
    repeat (60) @(negedge clk);
    check("ignored_rise_one_frame", frames_done, base + 1);

    // Rise in the done cycle starts the next frame with no idle gap.
    base = frames_done;
    exp_q.push_back(8'h3C);
    press(8'h3C);
    n = 0;
    while (bus_a.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", {31'd0, bus_a.done}, 32'd1);
    bus_a.data_in = 8'hC5;
    bus_a.send_in = 1'b1;
    exp_q.push_back(8'hC5);
    @(negedge clk);
    bus_a.send_in = 1'b0;
    check("b2b_no_gap", {30'd0, bus_a.tx, bus_a.busy}, 32'd1);
    wait_frames(base + 2);

    // Reset during data bit 3 aborts the frame without a done pulse.
    repeat (10) @(negedge clk);
    base = frames_done;
    n    = stray_done;
    press(8'h55);
    repeat (17) @(negedge clk);
    check("pre_reset_bit3", {31'd0, bus_a.tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tx", {31'd0, bus_a.tx}, 32'd1);
    check("midreset_busy", {31'd0, bus_a.busy}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midreset_no_frame", frames_done, base);
    check("midreset_no_done", stray_done, n);
    exp_q.push_back(8'h55);
    press(8'h55);
    wait_frames(base + 1);
    repeat (10) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("no_stray_done", stray_done, 32'd0);

    // Full-rate instance: measure start bit and first two data bits of 0x55.
    bus_b.data_in = 8'h55;
    @(negedge clk);
    #2 rst_b_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_b.send_in = 1'b1;
    @(negedge clk);
    bus_b.send_in = 1'b0;
    check("big_busy", {31'd0, bus_b.busy}, 32'd1);
    for (int s = 0; s < 3; s++) begin
      lvl = (s == 1);
      n   = 0;
      while (bus_b.tx === lvl && n < 20000) begin
        n++;
        @(negedge clk);
      end
      check("big_bit_period", n, CPB_B);
    end
    #2 rst_b_n = 1'b0;
    #1 check("big_reset_tx", {31'd0, bus_b.tx}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
